board_mem_arbiter: RTL and testbench

BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

---
 rtl/board_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_board_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
// Board RAM arbiter: shares one synchronous-read RAM port between the VGA
// board fetcher (priority, fully pipelined reads) and a CPU that can preempt
// VGA after waiting STARVE_MAX cycles. Grant is decided combinationally in
// the request cycle and issued on registered mem_* outputs one cycle later.
module board_mem_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        vga_req,
    input  logic [11:0] vga_addr,
    output logic [31:0] vga_data,
    output logic        vga_valid,
    output logic        vga_drop,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic [11:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] drop_count
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BUSY = 2'd2
    } cpuState_t;

    cpuState_t  cpuState, cpuStateNext;
    logic [7:0] waitCnt, waitCntNext;
    logic       cpuPending;
    logic       starved;
    logic       grantCpu;
    logic       grantVga;
    logic       dropNow;

    // Pipeline tags: stage 1 = address on mem_*, stage 2 = mem_rdata valid.
    logic       s1Vga, s1CpuRd, s1CpuWr;
    logic       s2Vga, s2CpuRd;

    // Arbitration, CPU next state and starvation counter for this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case/if tree can leave one unassigned and infer a latch.
        cpuStateNext = cpuState;
        waitCntNext  = waitCnt;

        cpuPending = (cpuState == WAIT) || ((cpuState == IDLE) && cpu_req);
        starved    = (waitCnt == STARVE_LIM);
        grantCpu   = cpuPending && (!vga_req || starved);
        grantVga   = vga_req && !grantCpu;
        dropNow    = vga_req && grantCpu;

        unique case (cpuState)
            IDLE: begin
                if (grantCpu)     cpuStateNext = BUSY;
                else if (cpu_req) cpuStateNext = WAIT;
            end
            WAIT: begin
                if (grantCpu) cpuStateNext = BUSY;
            end
            BUSY: begin
                if (cpu_ack) cpuStateNext = IDLE;
            end
            default: cpuStateNext = IDLE;
        endcase

        if (grantCpu)
            waitCntNext = 8'd0;
        else if (cpuPending && !starved)
            waitCntNext = waitCnt + 8'd1;
    end

    // CPU FSM state and starvation counter registers.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cpuState <= IDLE;
            waitCnt  <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            cpuState <= cpuStateNext;
            waitCnt  <= waitCntNext;
        end
    end

    // RAM command issue: registered address/write strobe for the granted side.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            mem_addr  <= 12'd0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= grantCpu && cpu_we;
            if (grantCpu) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (grantVga) begin
                mem_addr <= vga_addr;
            end
        end
    end

    // Read-return pipeline tags following each issued command.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            s1Vga   <= 1'b0;
            s1CpuRd <= 1'b0;
            s1CpuWr <= 1'b0;
            s2Vga   <= 1'b0;
            s2CpuRd <= 1'b0;
        end else begin
            s1Vga   <= grantVga;
            s1CpuRd <= grantCpu && !cpu_we;
            s1CpuWr <= grantCpu && cpu_we;
            s2Vga   <= s1Vga;
            s2CpuRd <= s1CpuRd;
        end
    end

    // Response outputs: data registers hold between completion pulses.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vga_valid <= 1'b0;
            vga_data  <= 32'd0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 32'd0;
        end else begin
            vga_valid <= s2Vga;
            cpu_ack   <= s1CpuWr || s2CpuRd;
            if (s2Vga)   vga_data  <= mem_rdata;
            if (s2CpuRd) cpu_rdata <= mem_rdata;
        end
    end

    // Preemption pulse and saturating drop counter.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vga_drop   <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            vga_drop <= dropNow;
            if (dropNow && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Scoreboard bench for board_mem_arbiter: stimulus pushes hand-timed expected
// responses into queues; a negedge monitor pops and compares them whenever the
// DUT presents vga_valid, cpu_ack, vga_drop or mem_we.
module tb_board_mem_arbiter;

    localparam int STARVE = 8;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        iVGA_CLK = 1'b0;
    logic        iRST_n;
    logic        vga_req;
    logic [11:0] vga_addr;
    logic [31:0] vga_data;
    logic        vga_valid;
    logic        vga_drop;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] drop_count;

    board_mem_arbiter #(.STARVE_MAX(STARVE)) dut (
        .iVGA_CLK  (iVGA_CLK),
        .iRST_n    (iRST_n),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_valid (vga_valid),
        .vga_drop  (vga_drop),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .drop_count(drop_count)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    int cyc = 0;
    always @(posedge iVGA_CLK) cyc <= cyc + 1;

    function automatic logic [31:0] initVal(input logic [11:0] a);
        return 32'hC0DE_0000 | {20'h0, a};
    endfunction

    // Board RAM: one-cycle synchronous read, unwritten words read initVal.
    bit [31:0] ram     [4096];
    bit        written [4096];
    always @(posedge iVGA_CLK) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : initVal(mem_addr);
    end

    // Reference contents, updated by the stimulus when it issues a write.
    logic [31:0] model [4096];

    exp_t vgaQ[$];
    exp_t cpuQ[$];
    exp_t dropQ[$];
    exp_t wrQ[$];

    int          nVec = 0;
    int          nMis = 0;
    logic [31:0] lastRd;
    logic [15:0] dropTrack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented response against the queue head.
    exp_t vE, cE, dE, wE;
    always @(negedge iVGA_CLK) begin
        if (vga_valid) begin
            if (vgaQ.size() == 0) check("vga_valid_unexpected", 32'(vga_valid), 32'd0);
            else begin
                vE = vgaQ.pop_front();
                check("vga_cycle", cyc, vE.cyc);
                check("vga_data", vga_data, vE.data);
            end
        end
        if (cpu_ack) begin
            if (cpuQ.size() == 0) check("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
            else begin
                cE = cpuQ.pop_front();
                check("cpu_ack_cycle", cyc, cE.cyc);
                check("cpu_rdata", cpu_rdata, cE.data);
            end
        end
        if (vga_drop) begin
            if (dropQ.size() == 0) check("vga_drop_unexpected", 32'(vga_drop), 32'd0);
            else begin
                dE = dropQ.pop_front();
                check("drop_cycle", cyc, dE.cyc);
                check("drop_count", 32'(drop_count), dE.data);
            end
        end
        if (mem_we) begin
            if (wrQ.size() == 0) check("mem_we_unexpected", 32'(mem_we), 32'd0);
            else begin
                wE = wrQ.pop_front();
                check("mem_we_cycle", cyc, wE.cyc);
                check("mem_addr", 32'(mem_addr), 32'(wE.addr));
                check("mem_wdata", mem_wdata, wE.data);
            end
        end
    end

    task automatic idleInputs();
        vga_req   = 1'b0;
        vga_addr  = 12'd0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 12'd0;
        cpu_wdata = 32'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iVGA_CLK);
            idleInputs();
        end
    endtask

    task automatic pushVga(input logic [11:0] a);
        vgaQ.push_back('{cyc + 3, a, model[a]});
    endtask

    task automatic pushCpuWrite(input logic [11:0] a, input logic [31:0] d);
        wrQ.push_back('{cyc + 1, a, d});
        cpuQ.push_back('{cyc + 2, a, lastRd});
        model[a] = d;
    endtask

    task automatic pushCpuRead(input logic [11:0] a);
        cpuQ.push_back('{cyc + 3, a, model[a]});
        lastRd = model[a];
    endtask

    task automatic pushDrop();
        if (dropTrack != 16'hFFFF) dropTrack = dropTrack + 16'd1;
        dropQ.push_back('{cyc + 1, 12'd0, 32'(dropTrack)});
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, "_vga_valid"}, 32'(vga_valid), 32'd0);
        check({tag, "_vga_drop"}, 32'(vga_drop), 32'd0);
        check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_vga_data"}, vga_data, 32'd0);
        check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        check({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    endtask

    // VGA requests every cycle with the CPU held pending from k=0: the CPU
    // preempts at k=STARVE, the rest of the VGA requests are served.
    task automatic starvePeriod(input logic we, input logic [11:0] ca,
                                input logic [31:0] wd, input logic [11:0] vBase);
        int len;
        len = we ? STARVE + 3 : STARVE + 4;
        for (int k = 0; k < len; k++) begin
            @(negedge iVGA_CLK);
            cpu_req   = 1'b1;
            cpu_we    = we;
            cpu_addr  = ca;
            cpu_wdata = wd;
            vga_req   = 1'b1;
            vga_addr  = 12'(vBase + 12'(k));
            if (k == STARVE) begin
                pushDrop();
                if (we) pushCpuWrite(ca, wd);
                else    pushCpuRead(ca);
            end else begin
                pushVga(vga_addr);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model[i] = initVal(12'(i));
        lastRd    = 32'd0;
        dropTrack = 16'd0;
        idleInputs();
        iRST_n = 1'b0;
        repeat (3) @(negedge iVGA_CLK);
        checkOutputsZero("reset");

        // Release reset and request in that same cycle; 20 back-to-back reads.
        for (int i = 0; i < 20; i++) begin
            @(negedge iVGA_CLK);
            if (i == 0) iRST_n = 1'b1;
            vga_req  = 1'b1;
            vga_addr = 12'(i * 3 + 1);
            pushVga(vga_addr);
        end
        idle(5);

        // CPU write then read-back with no VGA traffic.
        @(negedge iVGA_CLK);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h009; cpu_wdata = 32'h0000_0015;
        pushCpuWrite(12'h009, 32'h0000_0015);
        idle(4);
        @(negedge iVGA_CLK);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h009;
        pushCpuRead(12'h009);
        idle(6);

        // Starvation: CPU read preempts continuous VGA after STARVE cycles.
        starvePeriod(1'b0, 12'h009, 32'd0, 12'h040);
        idle(6);

        // VGA burst ends exactly as the CPU asks: CPU granted at once.
        for (int i = 0; i < 4; i++) begin
            @(negedge iVGA_CLK);
            vga_req  = 1'b1;
            vga_addr = 12'(12'h050 + i);
            pushVga(vga_addr);
        end
        @(negedge iVGA_CLK);
        vga_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 32'h0000_ABCD;
        pushCpuWrite(12'h020, 32'h0000_ABCD);
        idle(4);
        // Then a fresh CPU request against continuous VGA again waits the full STARVE.
        starvePeriod(1'b1, 12'h021, 32'h0000_1234, 12'h060);
        @(negedge iVGA_CLK);
        idleInputs();
        vga_req  = 1'b1;
        vga_addr = 12'h020;
        pushVga(12'h020);
        idle(6);

        // Reset with a CPU read BUSY and VGA reads in flight: nothing emerges.
        @(negedge iVGA_CLK);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h009;
        @(negedge iVGA_CLK);
        idleInputs();
        vga_req = 1'b1; vga_addr = 12'h001;
        @(negedge iVGA_CLK);
        vga_addr = 12'h002;
        iRST_n   = 1'b0;
        lastRd    = 32'd0;
        dropTrack = 16'd0;
        idle(3);
        checkOutputsZero("midreset");
        @(negedge iVGA_CLK);
        iRST_n = 1'b1;
        idle(8);

        // Drop counter saturation: preload near the top, then keep preempting.
        force dut.drop_count = 16'hFFFA;
        @(negedge iVGA_CLK);
        release dut.drop_count;
        dropTrack = 16'hFFFA;
        for (int p = 0; p < 8; p++)
            starvePeriod(1'b1, 12'(12'h300 + p), 32'(p + 1), 12'h200);
        idle(8);
        check("drop_count_saturated", 32'(drop_count), 32'h0000_FFFF);

        check("vga_queue_left", 32'(vgaQ.size()), 32'd0);
        check("cpu_queue_left", 32'(cpuQ.size()), 32'd0);
        check("drop_queue_left", 32'(dropQ.size()), 32'd0);
        check("write_queue_left", 32'(wrQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
